midi_par2ser: RTL and testbench

Serial MIDI transmitter: accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and shifts each out as a standard MIDI frame (1 start bit, 8 data bits LSB first, 1 stop bit) at 31 250 baud on the 500 kHz system clock. It sits between the game logic that generates MIDI messages and the MIDI OUT pin, and is the transmit counterpart of the MIDI byte receiver.

---
 rtl/midi_par2ser.sv | 89 ++++++++
 tb/tb_midi_par2ser.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/midi_par2ser.sv
// midi_par2ser: byte FIFO feeding a 31 250 baud MIDI serializer (start, 8 data LSB first, stop).
module midi_par2ser #(
    parameter int BIT_CLKS   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk500kHz,
    input  logic                               RST_N,
    input  logic [7:0]                         TX_BYTE,
    input  logic                               TX_VALID,
    output logic                               TX_READY,
    output logic                               MIDI_OUT,
    output logic                               TX_BUSY,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    FIFO_LEVEL
);
    localparam int TW = $clog2(BIT_CLKS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH+1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [TW-1:0] tick, tick_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, last_tick, has_data, line_n;

    assign TX_READY  = FIFO_LEVEL != LW'(FIFO_DEPTH);
    assign has_data  = FIFO_LEVEL != '0;
    assign TX_BUSY   = state != IDLE || has_data;
    assign push      = TX_VALID && TX_READY;
    assign last_tick = tick == TW'(BIT_CLKS-1);

    always_comb begin
        state_n = state;
        tick_n  = last_tick ? '0 : tick + TW'(1);
        bit_n   = bit_cnt;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                tick_n = '0;
                pop    = has_data;
                state_n = has_data ? START : IDLE;
            end
            START: if (last_tick) begin
                state_n = DATA;
                bit_n   = '0;
            end
            DATA: if (last_tick) begin
                shift_n = shift >> 1;
                bit_n   = bit_cnt + 3'd1;
                state_n = bit_cnt == 3'd7 ? STOP : DATA;
            end
            STOP: if (last_tick) begin
                pop     = has_data;
                state_n = has_data ? START : IDLE;
            end
        endcase
        if (pop) shift_n = mem[rd_ptr];
        // The line register follows the next state so each bit starts on its entry edge.
        line_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
    end

    always_ff @(posedge clk500kHz) if (push) mem[wr_ptr] <= TX_BYTE;

    always_ff @(posedge clk500kHz or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            tick       <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            MIDI_OUT   <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_LEVEL <= '0;
        end else begin
            state      <= state_n;
            tick       <= tick_n;
            bit_cnt    <= bit_n;
            shift      <= shift_n;
            MIDI_OUT   <= line_n;
            wr_ptr     <= wr_ptr + PW'(push);
            rd_ptr     <= rd_ptr + PW'(pop);
            FIFO_LEVEL <= FIFO_LEVEL + LW'(push) - LW'(pop);
        end
    end
endmodule

// File: tb/tb_midi_par2ser.sv
// tb_midi_par2ser: frame-table checks, corner sequences and a random stream against a timing model plus a line decoder.
module tb_midi_par2ser;
    localparam int BC = 16, DEPTH = 4, FL = 10*BC;

    logic       clk500kHz = 1'b0, RST_N = 1'b1, TX_VALID = 1'b0;
    logic [7:0] TX_BYTE = '0;
    logic       TX_READY, MIDI_OUT, TX_BUSY;
    logic [2:0] FIFO_LEVEL;

    always #5 clk500kHz = ~clk500kHz;

    midi_par2ser #(.BIT_CLKS(BC), .FIFO_DEPTH(DEPTH)) dut (
        .clk500kHz(clk500kHz), .RST_N(RST_N), .TX_BYTE(TX_BYTE), .TX_VALID(TX_VALID),
        .TX_READY(TX_READY), .MIDI_OUT(MIDI_OUT), .TX_BUSY(TX_BUSY), .FIFO_LEVEL(FIFO_LEVEL)
    );

    int         n_cmp = 0, n_bad = 0;
    logic [7:0] q[$], rxq[$];
    int         rem = 0, rx_frames = 0, accepted = 0, rx_cnt = 0;
    logic [7:0] cur = '0, rx_sh = '0;
    bit         rx_act = 0;

    typedef struct {logic [7:0] b; logic [9:0] frame;} vec_t;
    vec_t vecs[6];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a 10*BC-clock window; the line level is read from elapsed time.
    function automatic logic exp_line();
        int idx;
        if (rem == 0) return 1'b1;
        idx = (FL - rem) / BC;
        return idx == 0 ? 1'b0 : idx == 9 ? 1'b1 : cur[idx-1];
    endfunction

    task automatic cyc(logic v, logic [7:0] b);
        bit ps, pp;
        TX_VALID = v;
        TX_BYTE  = b;
        @(posedge clk500kHz);
        ps = v && q.size() < DEPTH;
        pp = q.size() > 0 && rem <= 1;
        if (pp) begin cur = q.pop_front(); rem = FL; end
        else if (rem > 0) rem--;
        if (ps) begin q.push_back(b); rxq.push_back(b); accepted++; end
        #1;
        chk("midi_out", MIDI_OUT, exp_line());
        chk("tx_ready", TX_READY, q.size() < DEPTH);
        chk("fifo_level", FIFO_LEVEL, q.size());
        chk("tx_busy", TX_BUSY, rem > 0 || q.size() > 0);
        TX_VALID = 1'b0;
    endtask

    task automatic do_reset();
        #2 RST_N = 1'b0;
        #1;
        chk("rst_midi_out", MIDI_OUT, 1);
        chk("rst_ready", TX_READY, 1);
        chk("rst_level", FIFO_LEVEL, 0);
        chk("rst_busy", TX_BUSY, 0);
        q.delete(); rxq.delete();
        rem = 0; rx_frames = 0; accepted = 0;
        repeat (2) @(posedge clk500kHz);
        #2 RST_N = 1'b1;
        cyc(0, 0);
    endtask

    // Independent line decoder: samples each bit at its centre on the falling clock edge.
    always @(negedge clk500kHz) begin
        if (!RST_N) rx_act = 0;
        else if (!rx_act) begin
            if (MIDI_OUT === 1'b0) begin rx_act = 1; rx_cnt = 0; end
        end else begin
            rx_cnt++;
            if (rx_cnt % BC == BC/2) begin
                if (rx_cnt / BC >= 1 && rx_cnt / BC <= 8) rx_sh[rx_cnt/BC - 1] = MIDI_OUT;
                if (rx_cnt / BC == 9) begin
                    chk("rx_stop", MIDI_OUT, 1);
                    chk("rx_expected_byte", rxq.size() > 0, 1);
                    if (rxq.size() > 0) chk("rx_byte", rx_sh, rxq.pop_front());
                    rx_frames++;
                    rx_act = 0;
                end
            end
        end
    end

    initial begin
        logic [7:0] burst[3];
        int peak, lo, fall, budget;
        vecs[0] = '{8'h90, 10'b1_10010000_0};
        vecs[1] = '{8'h55, 10'b1_01010101_0};
        vecs[2] = '{8'h3C, 10'b1_00111100_0};
        vecs[3] = '{8'h7F, 10'b1_01111111_0};
        vecs[4] = '{8'h00, 10'b1_00000000_0};
        vecs[5] = '{8'hFF, 10'b1_11111111_0};
        burst = '{8'h90, 8'h3C, 8'h7F};

        for (int i = 0; i < 6; i++) begin
            do_reset();
            cyc(1, vecs[i].b);
            for (int j = 1; j <= 170; j++) begin
                cyc(0, 0);
                if (j == 1) chk("first_low", MIDI_OUT, 0);
                if (j <= FL && (j-1) % BC == BC/2) chk("frame_bit", MIDI_OUT, vecs[i].frame[(j-1)/BC]);
                if (j == FL) chk("busy_last", TX_BUSY, 1);
                if (j == FL+1) begin chk("busy_end", TX_BUSY, 0); chk("line_idle", MIDI_OUT, 1); end
            end
            chk("single_frames", rx_frames, 1);
        end

        do_reset();
        cyc(1, 8'h55);
        repeat (50) cyc(0, 0);
        do_reset();
        repeat (200) cyc(0, 0);
        chk("no_resume_frames", rx_frames, 0);

        do_reset();
        peak = 0; lo = -1; fall = -1;
        for (int c = 1; c <= 600; c++) begin
            cyc(c <= 3, burst[(c-1)%3]);
            if (int'(FIFO_LEVEL) > peak) peak = FIFO_LEVEL;
            if (lo < 0 && MIDI_OUT == 1'b0) lo = c;
            if (fall < 0 && lo > 0 && TX_BUSY == 1'b0) fall = c;
        end
        chk("burst_peak", peak, 2);
        chk("burst_first_start", lo, 2);
        chk("burst_span", fall - lo, 3*FL);
        chk("burst_frames", rx_frames, 3);

        do_reset();
        for (int c = 1; c <= 6; c++) begin
            cyc(1, 8'hA0 + 8'(c));
            if (c == 5) chk("ovf_ready_low", TX_READY, 0);
        end
        chk("ovf_level", FIFO_LEVEL, 4);
        repeat (5*FL + 40) cyc(0, 0);
        chk("ovf_frames", rx_frames, 5);

        do_reset();
        cyc(1, 8'h11);
        cyc(1, 8'h22);
        repeat (FL-1) cyc(0, 0);
        cyc(1, 8'h33);
        chk("pp_level", FIFO_LEVEL, 1);
        chk("pp_start", MIDI_OUT, 0);
        repeat (2*FL + 40) cyc(0, 0);
        chk("pp_frames", rx_frames, 3);

        do_reset();
        budget = 0;
        while (accepted < 200 && budget < 60000) begin
            cyc($urandom_range(0, 99) < 2, 8'($urandom));
            budget++;
        end
        repeat ((DEPTH+2)*FL) cyc(0, 0);
        chk("rand_frames", rx_frames, accepted);
        chk("rand_all_received", rxq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
